prog_mod_counter: RTL and testbench

Run-time programmable modulo-M counter with start/stop control, up/down direction, continuous or one-shot mode, parallel load, and a terminal-count tick. It is the general-purpose successor to the fixed-modulus counter. It serves as the timebase for baud-rate generators, PWM periods, debounce windows and timer peripherals on the SoC bus. The modulus can change at run time and takes effect only at a wrap boundary, so there is no glitch.

---
 rtl/prog_mod_counter.sv | 94 +++++++++
 tb/tb_prog_mod_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/prog_mod_counter.sv
// Run-time programmable modulo-M counter: start/stop, up/down, continuous or one-shot, clamped parallel load.
// q/busy/done registered (1 edge after cause); max_tick combinational in the cycle before a wrap edge.
module prog_mod_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic         dir,
    input  logic [W-1:0] mod_m,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         max_tick,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] m_q, m_d;
    logic         busy_q, done_q;

    logic [W-1:0] m_samp;
    logic [W-1:0] term;
    logic [W-1:0] init_new;
    logic [W-1:0] load_clamp;
    logic         at_term;

    // init_new always uses the freshly sampled modulus, since every user of it also resamples m.
    always_comb begin
        m_samp     = (mod_m == '0) ? W'(1) : mod_m;
        term       = dir ? '0 : (m_q - W'(1));
        init_new   = dir ? (m_samp - W'(1)) : '0;
        load_clamp = (load_val >= m_q) ? (m_q - W'(1)) : load_val;
        at_term    = (cnt_q == term);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        if (stop) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d = S_RUN;
            cnt_d   = init_new;
            m_d     = m_samp;
        end else if (load) begin
            cnt_d   = load_clamp;
        end else if (state_q == S_RUN && en) begin
            if (!at_term) begin
                cnt_d = dir ? (cnt_q - W'(1)) : (cnt_q + W'(1));
            end else if (mode) begin
                state_d = S_DONE;
            end else begin
                cnt_d = init_new;
                m_d   = m_samp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            m_q     <= W'(1);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Gated by reset_n so an aborting reset never leaves a tick behind.
    assign max_tick = reset_n && (state_q == S_RUN) && en && at_term && !stop && !start && !load;
    assign q        = cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed bench for prog_mod_counter: cycle-by-cycle comparison against an arithmetic model plus literal spot checks.
module tb_prog_mod_counter;

    logic        clk = 1'b0;
    logic        reset_n, en, start, stop, mode, dir, load;
    logic [15:0] mod_m, load_val;
    logic [15:0] q;
    logic        max_tick, busy, done;

    int tests = 0;
    int fails = 0;

    prog_mod_counter #(.W(16)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .start(start), .stop(stop),
        .mode(mode), .dir(dir), .mod_m(mod_m), .load(load), .load_val(load_val),
        .q(q), .max_tick(max_tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 run, 2 done; count mq lives in [0, mm-1].
    int  ph = 0, mq = 0, mm = 1, eff, last;
    bit  armed = 0;

    always @(posedge clk) begin
        armed = 1;
        eff   = (mod_m == 0) ? 1 : int'(mod_m);
        last  = dir ? 0 : mm - 1;
        if (!reset_n) begin
            ph = 0; mq = 0; mm = 1;
        end else if (stop) begin
            ph = 0;
        end else if (start) begin
            mm = eff; ph = 1; mq = dir ? mm - 1 : 0;
        end else if (load) begin
            mq = (int'(load_val) < mm) ? int'(load_val) : mm - 1;
        end else if (ph == 1 && en) begin
            if (mq != last)   mq = (mq + (dir ? mm - 1 : 1)) % mm;
            else if (mode)    ph = 2;
            else begin        mm = eff; mq = dir ? mm - 1 : 0; end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("q", 32'(q), 32'(mq));
            chk("busy", 32'(busy), 32'(ph == 1));
            chk("done", 32'(done), 32'(ph == 2));
            chk("max_tick", 32'(max_tick),
                32'(reset_n && ph == 1 && en && !stop && !start && !load && mq == (dir ? 0 : mm - 1)));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int ticks, prev_tick, period;

    initial begin
        reset_n = 0; start = 1; stop = 0; en = 0; mode = 0; dir = 0;
        mod_m = 16'd10; load = 0; load_val = 0;
        cyc(3);
        chk("rst_q", 32'(q), 0); chk("rst_busy", 32'(busy), 0); chk("rst_done", 32'(done), 0);
        start = 0; reset_n = 1;
        cyc();
        chk("idle_q", 32'(q), 0);

        // Continuous up, modulus 10.
        en = 1; start = 1; cyc(); start = 0;
        chk("cont_start_q", 32'(q), 0); chk("cont_busy", 32'(busy), 1);
        ticks = 0; prev_tick = -1; period = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (max_tick) begin
                chk("cont_tick_q", 32'(q), 9);
                if (prev_tick >= 0) period = i - prev_tick;
                prev_tick = i; ticks++;
            end
            cyc();
        end
        chk("cont_ticks", 32'(ticks), 5); chk("cont_period", 32'(period), 10);
        chk("cont_end_q", 32'(q), 0);

        // Modulus change to 4 at q=3 only applies at the wrap.
        cyc(3); chk("modchg_q3", 32'(q), 3);
        mod_m = 16'd4;
        cyc(6); #1;
        chk("modchg_q9", 32'(q), 9); chk("modchg_tick9", 32'(max_tick), 1);
        cyc(); chk("modchg_wrap", 32'(q), 0);
        cyc(3); #1;
        chk("modchg_q3b", 32'(q), 3); chk("modchg_tick3", 32'(max_tick), 1);
        cyc(); chk("modchg_wrap2", 32'(q), 0);

        // Stop at terminal: no tick, idle, q holds.
        cyc(3); stop = 1; #1;
        chk("stop_tick", 32'(max_tick), 0);
        cyc(); stop = 0;
        chk("stop_q", 32'(q), 3); chk("stop_busy", 32'(busy), 0);

        // One-shot down, modulus 5.
        mode = 1; dir = 1; mod_m = 16'd5; start = 1; cyc(); start = 0;
        chk("os_q4", 32'(q), 4);
        cyc(4); #1;
        chk("os_q0", 32'(q), 0); chk("os_tick", 32'(max_tick), 1);
        cyc();
        chk("os_done", 32'(done), 1); chk("os_busy", 32'(busy), 0); chk("os_hold", 32'(q), 0);
        cyc(2); #1;
        chk("os_done_hold", 32'(done), 1); chk("os_no_tick", 32'(max_tick), 0);
        start = 1; cyc(); start = 0;
        chk("os_restart", 32'(q), 4); chk("os_rdone", 32'(done), 0);

        // Load and clamp with m=10, up.
        mode = 0; dir = 0; mod_m = 16'd10; start = 1; cyc(); start = 0;
        cyc(2); chk("ld_pre", 32'(q), 2);
        load = 1; load_val = 16'd7; cyc(); load = 0;
        chk("ld_7", 32'(q), 7);
        load = 1; load_val = 16'd25; cyc(); load = 0; #1;
        chk("ld_clamp", 32'(q), 9); chk("ld_tick", 32'(max_tick), 1);
        cyc(); chk("ld_wrap", 32'(q), 0);
        cyc(2);
        load = 1; load_val = 16'd5; start = 1; cyc(); load = 0; start = 0;
        chk("ld_start", 32'(q), 0);

        // mod_m = 0 behaves as modulus 1.
        mod_m = 16'd0; start = 1; cyc(); start = 0;
        ticks = 0;
        for (int i = 0; i < 5; i++) begin
            #1; if (max_tick) ticks++;
            chk("m0_q", 32'(q), 0);
            cyc();
        end
        chk("m0_ticks", 32'(ticks), 5);

        // en toggling with modulus 4.
        mod_m = 16'd4; start = 1; cyc(); start = 0;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            en = (i % 2 == 0); #1;
            if (!en && max_tick) ticks++;
            cyc();
        end
        chk("en_q", 32'(q), 0); chk("en_off_ticks", 32'(ticks), 0);

        // Direction flip at 0: down wraps to m-1.
        en = 1; dir = 1; #1;
        chk("dir_tick", 32'(max_tick), 1);
        cyc(); chk("dir_wrap", 32'(q), 3);
        cyc(); chk("dir_step", 32'(q), 2);

        // Reset mid-run at terminal: no tick, aborts.
        cyc(2); #1; chk("mid_tick_pre", 32'(max_tick), 1);
        reset_n = 0; #1; chk("mid_rst_tick", 32'(max_tick), 0);
        cyc(); chk("mid_rst_q", 32'(q), 0); chk("mid_rst_busy", 32'(busy), 0);
        reset_n = 1; cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
